// File: rtl/inst_encoder_pkg.sv
// inst_enc_pkg: shared RV32I field formats, opcodes and immediate limits
package inst_enc_pkg;
  typedef enum logic [1:0] {
    FMT_R      = 2'd0,
    FMT_I_LOAD = 2'd1,
    FMT_I_ALU  = 2'd2,
    FMT_S      = 2'd3
  } fmt_e;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam int IMM_MIN = -2048;
  localparam int IMM_MAX = 2047;
endpackage

// File: rtl/inst_pack.sv
// inst_pack: combinational packing of decoded fields into one RV32I word plus range check
module inst_pack
  import inst_enc_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  f3,
  input  logic [6:0]  f7,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        imm_ok
);
  logic [6:0] op;
  // select opcode, lay out the fields for the format and check the 12-bit signed range
  always_comb begin
    op     = fmt == FMT_R ? OP_R : fmt == FMT_I_LOAD ? OP_LOAD : fmt == FMT_I_ALU ? OP_IMM : OP_STORE;
    word   = fmt == FMT_R ? {f7, rs2, rs1, f3, rd, op} :
             fmt == FMT_S ? {imm[11:5], rs2, rs1, f3, imm[4:0], op} :
                            {imm[11:0], rs1, f3, rd, op};
    imm_ok = fmt == FMT_R || ($signed(imm) >= IMM_MIN && $signed(imm) <= IMM_MAX);
  end
endmodule

// File: rtl/inst_encoder.sv
// inst_encoder: streams packed RV32I words with sequential addresses, dropping unencodable immediates
module inst_encoder
  import inst_enc_pkg::*;
#(
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64,
  parameter int ERR_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic              err_flag,
  output logic [ERR_W-1:0]  err_count
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FULL = 2'd2;
  logic [1:0]        state_q, state_d;
  logic              out_valid_q, out_valid_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              err_flag_q, err_flag_d;
  logic [ERR_W-1:0]  err_count_q, err_count_d;
  logic [31:0]       word;
  logic              imm_ok, accept, emit, drop;

  inst_pack u_pack (
    .fmt    (fmt_e'(in_fmt)),
    .rd     (in_rd),
    .rs1    (in_rs1),
    .rs2    (in_rs2),
    .f3     (in_funct3),
    .f7     (in_funct7),
    .imm    (in_imm),
    .word   (word),
    .imm_ok (imm_ok)
  );

  assign in_ready  = state_q == S_RUN && !start && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_inst  = out_inst_q;
  assign out_addr  = out_addr_q;
  assign full      = state_q == S_FULL;
  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;

  // next state: start restarts the program but keeps a pending output word untouched
  always_comb begin
    accept      = in_valid && in_ready;
    emit        = accept && imm_ok;
    drop        = accept && !imm_ok;
    state_d     = start ? S_RUN : (emit && cnt_q == (ADDR_W+1)'(DEPTH - 1)) ? S_FULL : state_q;
    out_valid_d = emit || (out_valid_q && !out_ready);
    out_inst_d  = emit ? word : out_inst_q;
    out_addr_d  = emit ? cnt_q[ADDR_W-1:0] : out_addr_q;
    cnt_d       = start ? '0 : emit ? cnt_q + 1'b1 : cnt_q;
    err_flag_d  = !start && (err_flag_q || drop);
    err_count_d = start ? '0 : (drop && !(&err_count_q)) ? err_count_q + 1'b1 : err_count_q;
  end

  // register all state with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_addr_q  <= '0;
      cnt_q       <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_addr_q  <= out_addr_d;
      cnt_q       <= cnt_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench with a field-level reference model of the encoder
module tb_inst_encoder;
  localparam int ADDR_W = 6;
  localparam int DEPTH  = 4;
  localparam int ERR_W  = 8;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, out_ready;
  logic [1:0] in_fmt;
  logic [4:0] in_rd, in_rs1, in_rs2;
  logic [2:0] in_funct3;
  logic [6:0] in_funct7;
  logic [31:0] in_imm;
  logic in_ready, out_valid, full, err_flag;
  logic [31:0] out_inst;
  logic [ADDR_W-1:0] out_addr;
  logic [ERR_W-1:0] err_count;

  inst_encoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_addr(out_addr),
    .full(full), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    int addr;
    int fmt;
    int imm;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit fits(int f, int imm);
    return f == 0 || (imm >= -2048 && imm <= 2047);
  endfunction

  function automatic logic [31:0] enc(int f, int rd, int rs1, int rs2, int f3, int f7, int imm);
    logic [31:0] u;
    logic [31:0] base;
    u = 32'(imm) & 32'hFFF;
    base = 32'(f3) << 12 | 32'(rs1) << 15;
    case (f)
      0: return 32'h33 | base | 32'(rd) << 7 | 32'(rs2) << 20 | 32'(f7) << 25;
      1: return 32'h03 | base | 32'(rd) << 7 | u << 20;
      2: return 32'h13 | base | 32'(rd) << 7 | u << 20;
      default: return 32'h23 | base | (u & 32'h1F) << 7 | 32'(rs2) << 20 | (u >> 5) << 25;
    endcase
  endfunction

  function automatic int dec(logic [31:0] w, int f);
    logic [31:0] x;
    x = f == 3 ? {{20{w[31]}}, w[31:25], w[11:7]} : {{20{w[31]}}, w[31:20]};
    return int'(x);
  endfunction

  bit running, mfull, mov, merr, er, acc, ok;
  int mcnt, merrc;

  // reference model: decides acceptance for the coming edge and queues the expected word
  always @(negedge clk) begin
    if (!rst_n) begin
      running = 0; mfull = 0; mov = 0; merr = 0; mcnt = 0; merrc = 0;
      q.delete();
    end else begin
      er = running && !start && (!mov || out_ready);
      chk("in_ready", 64'(in_ready), 64'(er));
      chk("full", 64'(full), 64'(mfull));
      chk("err_flag", 64'(err_flag), 64'(merr));
      chk("err_count", 64'(err_count), 64'(merrc));
      acc = in_valid && er;
      ok = acc && fits(int'(in_fmt), int'(in_imm));
      if (start) begin
        running = 1; mfull = 0; mcnt = 0; merr = 0; merrc = 0;
      end else if (ok) begin
        q.push_back('{enc(int'(in_fmt), int'(in_rd), int'(in_rs1), int'(in_rs2), int'(in_funct3),
                         int'(in_funct7), int'(in_imm)), mcnt, int'(in_fmt), int'(in_imm)});
        mcnt++;
        if (mcnt == DEPTH) begin
          running = 0; mfull = 1;
        end
      end else if (acc) begin
        merr = 1;
        merrc = merrc < 255 ? merrc + 1 : 255;
      end
      mov = ok || (mov && !out_ready);
    end
  end

  // monitor: compares each presented word with the queue head and pops on handshake
  always begin
    @(posedge clk);
    #2;
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    if (out_valid && q.size() != 0) begin
      chk("out_inst", 64'(out_inst), 64'(q[0].inst));
      chk("out_addr", 64'(out_addr), 64'(q[0].addr));
      if (q[0].fmt != 0) chk("imm_roundtrip", 64'(dec(out_inst, q[0].fmt)), 64'(q[0].imm));
      if (out_ready) void'(q.pop_front());
    end
  end

  task automatic drv(bit v, int f, int rd, int rs1, int rs2, int f3, int f7, int imm, bit st, bit ordy);
    in_valid = v; in_fmt = 2'(f); in_rd = 5'(rd); in_rs1 = 5'(rs1); in_rs2 = 5'(rs2);
    in_funct3 = 3'(f3); in_funct7 = 7'(f7); in_imm = 32'(imm); start = st; out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rst();
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_inst", 64'(out_inst), 64'(0));
    chk("rst_out_addr", 64'(out_addr), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst_err_flag", 64'(err_flag), 64'(0));
    chk("rst_err_count", 64'(err_count), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(0));
  endtask

  initial begin
    rst_n = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk_rst();
    rst_n = 1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drv(1, 2, 1, 0, 0, 0, 0, 5, 0, 1);
    drv(1, 3, 0, 1, 2, 2, 0, -4, 0, 1);
    drv(1, 0, 3, 1, 2, 0, 0, 0, 0, 1);
    drv(1, 1, 1, 1, 0, 2, 0, 2048, 0, 1);
    drv(1, 2, 5, 6, 0, 0, 0, -2048, 0, 1);
    drv(1, 2, 5, 6, 0, 0, 0, 2047, 0, 1);
    drv(1, 2, 5, 6, 0, 0, 0, 2047, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drv(1, 2, 7, 8, 0, 0, 0, 100, 0, 0);
    repeat (3) drv(1, 0, 9, 10, 11, 0, 32, 0, 0, 0);
    drv(1, 0, 9, 10, 11, 0, 32, 0, 0, 1);
    drv(1, 3, 0, 4, 5, 1, 0, -2047, 0, 1);
    drv(1, 1, 12, 13, 0, 4, 0, -1, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drv(1, 2, 1, 2, 0, 0, 0, 7, 0, 1);
    rst_n = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk_rst();
    rst_n = 1;
    drv(1, 2, 1, 2, 0, 0, 0, 7, 0, 1);
    drv(1, 2, 1, 2, 0, 0, 0, 7, 0, 1);
    for (int i = 0; i < 3000; i++) begin
      int r, imm;
      r = int'($urandom_range(0, 9));
      case (r)
        6: imm = 2047;
        7: imm = -2048;
        8: imm = $urandom_range(0, 1) != 0 ? 2048 : -2049;
        9: imm = int'($urandom());
        default: imm = int'($urandom_range(0, 4095)) - 2048;
      endcase
      rst_n = $urandom_range(0, 199) != 0;
      drv($urandom_range(0, 3) != 0, int'($urandom_range(0, 3)), int'($urandom_range(0, 31)),
          int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 127)), imm, $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);
    end
    rst_n = 1;
    repeat (4) drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("drain", 64'(q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
